icache_m1: RTL and testbench



---
 rtl/Types_m1.sv | 19 +
 rtl/icache_data_array_m1.sv | 25 ++
 rtl/icache_m1.sv | 122 ++++++++++++
 tb/tb_icache_m1.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/Types_m1.sv
// Shared types and default geometry for the m1 core blocks.
// The instruction cache derives its address split from these widths.
package Types_m1;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL
    } icache_state_t;

    localparam int IC_ADDR_W     = 15;
    localparam int IC_WORD_W     = 16;
    localparam int IC_LINE_WORDS = 4;
    localparam int IC_NUM_LINES  = 32;
    localparam int IC_OFF_W      = $clog2(IC_LINE_WORDS);
    localparam int IC_IDX_W      = $clog2(IC_NUM_LINES);
    localparam int IC_TAG_W      = IC_ADDR_W - IC_OFF_W - IC_IDX_W;

endpackage

// File: rtl/icache_data_array_m1.sv
// Instruction word storage: asynchronous read port, one synchronous write port.
// Addressed by {line index, word offset}.
module icache_data_array_m1 #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/icache_m1.sv
// Direct-mapped read-only instruction cache with blocking line refill
// and single-cycle flash invalidate.
module icache_m1
    import Types_m1::*;
#(
    parameter int LINE_WORDS = IC_LINE_WORDS,
    parameter int NUM_LINES  = IC_NUM_LINES
) (
    input  logic        clk,
    input  logic        sync_rst,
    input  logic        clk_en,
    input  logic        icache_req,
    input  logic [14:0] inst_address_in,
    output logic [15:0] instruction_out,
    output logic        icache_miss,
    input  logic        invalidate,
    output logic        fill_req,
    output logic [14:0] fill_addr,
    input  logic        fill_ack,
    input  logic        fill_valid,
    input  logic [15:0] fill_data
);

    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = IC_ADDR_W - OFF_W - IDX_W;

    icache_state_t         state_q;
    logic [IC_ADDR_W-1:0]  fillAddr_q;
    logic [OFF_W-1:0]      beat_q;
    logic                  kill_q;
    logic [NUM_LINES-1:0]  valid_q;
    logic [TAG_W-1:0]      tagRam_q [NUM_LINES];

    logic [IDX_W-1:0]      reqIdx;
    logic [TAG_W-1:0]      reqTag;
    logic [IDX_W-1:0]      fillIdx;
    logic [TAG_W-1:0]      fillTag;
    logic                  hit;
    logic                  lastBeat;
    logic                  dataWe;
    logic [IC_WORD_W-1:0]  rdData;

    assign reqIdx   = inst_address_in[OFF_W +: IDX_W];
    assign reqTag   = inst_address_in[IC_ADDR_W-1 -: TAG_W];
    assign fillIdx  = fillAddr_q[OFF_W +: IDX_W];
    assign fillTag  = fillAddr_q[IC_ADDR_W-1 -: TAG_W];

    // Lookups are only trusted while no refill is in progress.
    assign hit      = valid_q[reqIdx] && (tagRam_q[reqIdx] == reqTag) && (state_q == IDLE);
    assign lastBeat = (state_q == FILL) && fill_valid && (beat_q == OFF_W'(LINE_WORDS - 1));
    assign dataWe   = clk_en && !sync_rst && (state_q == FILL) && fill_valid;

    assign icache_miss     = icache_req && !hit;
    assign instruction_out = hit ? rdData : '0;
    assign fill_req        = (state_q == REQ);
    assign fill_addr       = fillAddr_q;

    icache_data_array_m1 #(
        .ADDR_W (IDX_W + OFF_W),
        .DATA_W (IC_WORD_W)
    ) u_data (
        .clk   (clk),
        .we    (dataWe),
        .waddr ({fillIdx, beat_q}),
        .wdata (fill_data),
        .raddr ({reqIdx, inst_address_in[OFF_W-1:0]}),
        .rdata (rdData)
    );

    always_ff @(posedge clk) begin
        if (clk_en && !sync_rst && lastBeat) begin
            tagRam_q[fillIdx] <= fillTag;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_rst) begin
            state_q    <= IDLE;
            fillAddr_q <= '0;
            beat_q     <= '0;
            kill_q     <= 1'b0;
            valid_q    <= '0;
        end else if (clk_en) begin
            if (invalidate) begin
                valid_q <= '0;
                if (state_q != IDLE) begin
                    kill_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: begin
                    if (icache_req && !hit) begin
                        state_q    <= REQ;
                        fillAddr_q <= {inst_address_in[IC_ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                        beat_q     <= '0;
                        kill_q     <= 1'b0;
                    end
                end
                REQ: begin
                    if (fill_ack) begin
                        state_q <= FILL;
                    end
                end
                FILL: begin
                    if (fill_valid) begin
                        beat_q <= beat_q + 1'b1;
                    end
                    // An invalidate landing on the final beat kills the line too.
                    if (lastBeat) begin
                        state_q <= IDLE;
                        if (!kill_q && !invalidate) begin
                            valid_q[fillIdx] <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_m1.sv
// Randomized scoreboard bench for icache_m1 against a line-level cache model
// with a fixed synthetic instruction memory.
module tb_icache_m1;

    localparam int NUM_CYCLES = 3000;
    localparam int PH_IDLE    = 0;
    localparam int PH_ACK     = 1;
    localparam int PH_BEATS   = 2;

    logic        clk = 1'b0;
    logic        sync_rst;
    logic        clk_en;
    logic        icache_req;
    logic [14:0] inst_address_in;
    logic [15:0] instruction_out;
    logic        icache_miss;
    logic        invalidate;
    logic        fill_req;
    logic [14:0] fill_addr;
    logic        fill_ack;
    logic        fill_valid;
    logic [15:0] fill_data;

    always #5 clk = ~clk;

    icache_m1 dut (
        .clk             (clk),
        .sync_rst        (sync_rst),
        .clk_en          (clk_en),
        .icache_req      (icache_req),
        .inst_address_in (inst_address_in),
        .instruction_out (instruction_out),
        .icache_miss     (icache_miss),
        .invalidate      (invalidate),
        .fill_req        (fill_req),
        .fill_addr       (fill_addr),
        .fill_ack        (fill_ack),
        .fill_valid      (fill_valid),
        .fill_data       (fill_data)
    );

    typedef struct {
        logic        miss;
        logic [15:0] data;
        logic        fillReq;
        logic [14:0] fillAddr;
    } exp_t;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state: which memory line each cache slot holds, plus the
    // progress of the one outstanding memory-port transaction.
    bit          mValid [32];
    logic [7:0]  mTag   [32];
    int          phase  = PH_IDLE;
    logic [14:0] mFillAddr = '0;
    int          mBeats = 0;
    bit          mKill  = 1'b0;

    function automatic logic [15:0] memWord(input logic [14:0] a);
        logic [31:0] w;
        w = {17'd0, a} * 32'd40503;
        return w[15:0] ^ 16'h1234;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
        phase     = PH_IDLE;
        mFillAddr = '0;
        mBeats    = 0;
        mKill     = 1'b0;
    endtask

    task automatic applyStimulus(input bit forceRst);
        exp_t        e;
        logic [4:0]  idx;
        logic [7:0]  tag;
        bit          hit;

        sync_rst        = forceRst || ($urandom_range(0, 199) == 0);
        clk_en          = ($urandom_range(0, 9) != 0);
        icache_req      = ($urandom_range(0, 4) != 0);
        inst_address_in = {8'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
        invalidate      = ($urandom_range(0, 39) == 0);
        fill_ack        = (phase == PH_ACK) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        if (phase == PH_BEATS) begin
            fill_valid = ($urandom_range(0, 2) != 0);
            fill_data  = memWord(15'(mFillAddr + 15'(mBeats)));
        end else begin
            fill_valid = ($urandom_range(0, 3) == 0);
            fill_data  = 16'($urandom);
        end

        idx = inst_address_in[6:2];
        tag = inst_address_in[14:7];
        hit = (phase == PH_IDLE) && mValid[idx] && (mTag[idx] == tag);

        e.miss     = icache_req && !hit;
        e.data     = hit ? memWord(inst_address_in) : 16'h0;
        e.fillReq  = (phase == PH_ACK);
        e.fillAddr = mFillAddr;
        expQ.push_back(e);

        // Advance the model to what the coming clock edge should produce.
        if (sync_rst) begin
            modelReset();
        end else if (clk_en) begin
            if (invalidate) begin
                for (int i = 0; i < 32; i++) mValid[i] = 1'b0;
                if (phase != PH_IDLE) mKill = 1'b1;
            end
            if (phase == PH_IDLE) begin
                if (icache_req && !hit) begin
                    phase     = PH_ACK;
                    mFillAddr = {inst_address_in[14:2], 2'b00};
                    mBeats    = 0;
                    mKill     = 1'b0;
                end
            end else if (phase == PH_ACK) begin
                if (fill_ack) phase = PH_BEATS;
            end else if (fill_valid) begin
                mBeats++;
                if (mBeats == 4) begin
                    phase = PH_IDLE;
                    if (!mKill) begin
                        mValid[mFillAddr[6:2]] = 1'b1;
                        mTag[mFillAddr[6:2]]   = mFillAddr[14:7];
                    end
                end
            end
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("icache_miss", 32'(icache_miss), 32'(e.miss));
                checkOutput("instruction_out", 32'(instruction_out), 32'(e.data));
                checkOutput("fill_req", 32'(fill_req), 32'(e.fillReq));
                checkOutput("fill_addr", 32'(fill_addr), 32'(e.fillAddr));
            end
        end
    end

    initial begin
        sync_rst        = 1'b1;
        clk_en          = 1'b1;
        icache_req      = 1'b0;
        inst_address_in = '0;
        invalidate      = 1'b0;
        fill_ack        = 1'b0;
        fill_valid      = 1'b0;
        fill_data       = '0;
        modelReset();
        for (int i = 0; i < 32; i++) mTag[i] = '0;

        for (int cyc = 0; cyc < NUM_CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            applyStimulus(cyc < 2);
        end
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
